// File: rtl/v_w_divider_multi.sv
// rtl/v_w_divider_multi.sv - multi-scale V/W and |V|/W_T divider with sideband pipeline and credit-throttled output FIFO

module floating_point_divider #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int LATENCY    = 8,
  localparam int FP_WIDTH  = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic                clk_i,
  input  logic [FP_WIDTH-1:0] a_i,
  input  logic [FP_WIDTH-1:0] b_i,
  output logic [FP_WIDTH-1:0] y_o
);

  localparam int M  = FRAC_WIDTH + 1;
  localparam int QW = M + 3;
  localparam int NW = 2 * M + 2;
  localparam logic [EXP_WIDTH-1:0] EMAX = '1;
  localparam logic signed [EXP_WIDTH+1:0] BIAS_S = (EXP_WIDTH+2)'((1 << (EXP_WIDTH - 1)) - 1);
  localparam logic signed [EXP_WIDTH+1:0] EMAX_S = (EXP_WIDTH+2)'((1 << EXP_WIDTH) - 1);
  localparam logic signed [EXP_WIDTH+1:0] ONE_S  = (EXP_WIDTH+2)'(1);

  logic                         sa, sb, sign;
  logic [EXP_WIDTH-1:0]         ea, eb;
  logic [FRAC_WIDTH-1:0]        fa, fb, frac_t;
  logic                         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [NW-1:0]                num, den;
  logic [QW-1:0]                q;
  logic [M-1:0]                 rem;
  logic                         guard, sticky, round_up;
  logic [FRAC_WIDTH:0]          frac_r;
  logic signed [EXP_WIDTH+1:0]  exp_s;
  logic [FP_WIDTH-1:0]          res;
  logic [FP_WIDTH-1:0]          pipe [LATENCY];

  // Denormal operands are flushed to zero; round-to-nearest-even on the quotient.
  always_comb begin
    {sa, ea, fa} = a_i;
    {sb, eb, fb} = b_i;
    sign   = sa ^ sb;
    a_nan  = (ea == EMAX) && (fa != '0);
    b_nan  = (eb == EMAX) && (fb != '0);
    a_inf  = (ea == EMAX) && (fa == '0);
    b_inf  = (eb == EMAX) && (fb == '0);
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    num    = {1'b1, fa, {(M+2){1'b0}}};
    den    = {{(M+2){1'b0}}, 1'b1, fb};
    q      = QW'(num / den);
    rem    = M'(num % den);
    exp_s  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_S;
    if (q[QW-1]) begin
      frac_t = q[QW-2:3];
      guard  = q[2];
      sticky = (|q[1:0]) || (rem != '0);
    end else begin
      frac_t = q[QW-3:2];
      guard  = q[1];
      sticky = q[0] || (rem != '0);
      exp_s  = exp_s - ONE_S;
    end
    round_up = guard && (sticky || frac_t[0]);
    frac_r   = {1'b0, frac_t} + {{FRAC_WIDTH{1'b0}}, round_up};
    if (frac_r[FRAC_WIDTH]) exp_s = exp_s + ONE_S;
    res = {sign, exp_s[EXP_WIDTH-1:0], frac_r[FRAC_WIDTH-1:0]};
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero))
      res = {1'b0, EMAX, 1'b1, {(FRAC_WIDTH-1){1'b0}}};
    else if (a_inf || b_zero)
      res = {sign, EMAX, {FRAC_WIDTH{1'b0}}};
    else if (a_zero || b_inf)
      res = {sign, {(EXP_WIDTH+FRAC_WIDTH){1'b0}}};
    else if (exp_s >= EMAX_S)
      res = {sign, EMAX, {FRAC_WIDTH{1'b0}}};
    else if (exp_s < ONE_S)
      res = {sign, {(EXP_WIDTH+FRAC_WIDTH){1'b0}}};
  end

  always_ff @(posedge clk_i) begin
    pipe[0] <= res;
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end

  assign y_o = pipe[LATENCY-1];

endmodule

module v_w_divider_multi #(
  parameter int EXP_WIDTH   = 8,
  parameter int FRAC_WIDTH  = 23,
  parameter int NUM_SCALES  = 2,
  parameter int DIV_LATENCY = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int COORD_WIDTH = 16,
  localparam int FP_WIDTH   = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_SCALES*FP_WIDTH-1:0] v_i,
  input  logic [NUM_SCALES*FP_WIDTH-1:0] w_i,
  input  logic [NUM_SCALES*FP_WIDTH-1:0] w_t_i,
  input  logic [COORD_WIDTH-1:0]         col_i,
  input  logic [COORD_WIDTH-1:0]         row_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  output logic [NUM_SCALES*FP_WIDTH-1:0] z_o,
  output logic [NUM_SCALES*FP_WIDTH-1:0] c_o,
  output logic [NUM_SCALES-1:0]          zero_w_o,
  output logic [COORD_WIDTH-1:0]         col_o,
  output logic [COORD_WIDTH-1:0]         row_o,
  output logic                           valid_o,
  input  logic                           ready_i
);

  localparam int VW    = NUM_SCALES * FP_WIDTH;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  logic                   accept, exit_vld, pop;
  logic [NUM_SCALES-1:0]  zw_in, wtz_in;
  logic [VW-1:0]          z_div, c_div, z_exit, c_exit;

  logic [DIV_LATENCY-1:0] vld_pipe;
  logic [COORD_WIDTH-1:0] col_pipe [DIV_LATENCY];
  logic [COORD_WIDTH-1:0] row_pipe [DIV_LATENCY];
  logic [NUM_SCALES-1:0]  zw_pipe  [DIV_LATENCY];
  logic [NUM_SCALES-1:0]  wtz_pipe [DIV_LATENCY];

  logic [CNT_W-1:0]       inflight, fifo_count;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [VW-1:0]          mem_z   [FIFO_DEPTH];
  logic [VW-1:0]          mem_c   [FIFO_DEPTH];
  logic [NUM_SCALES-1:0]  mem_zw  [FIFO_DEPTH];
  logic [COORD_WIDTH-1:0] mem_col [FIFO_DEPTH];
  logic [COORD_WIDTH-1:0] mem_row [FIFO_DEPTH];

  assign accept = valid_i && ready_o;
  assign ready_o = ({1'b0, fifo_count} + {1'b0, inflight}) < {1'b0, DEPTH_C};

  for (genvar s = 0; s < NUM_SCALES; s++) begin : g_scale
    // Sign of W/W_T is irrelevant to the zero test, so only exponent+fraction are compared.
    assign zw_in[s]  = (w_i[s*FP_WIDTH +: FP_WIDTH-1] == '0);
    assign wtz_in[s] = (w_t_i[s*FP_WIDTH +: FP_WIDTH-1] == '0);

    floating_point_divider #(
      .EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH), .LATENCY(DIV_LATENCY)
    ) u_div_z (
      .clk_i (clk_i),
      .a_i   (v_i[s*FP_WIDTH +: FP_WIDTH]),
      .b_i   (w_i[s*FP_WIDTH +: FP_WIDTH]),
      .y_o   (z_div[s*FP_WIDTH +: FP_WIDTH])
    );

    floating_point_divider #(
      .EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH), .LATENCY(DIV_LATENCY)
    ) u_div_c (
      .clk_i (clk_i),
      .a_i   ({1'b0, v_i[s*FP_WIDTH +: FP_WIDTH-1]}),
      .b_i   (w_t_i[s*FP_WIDTH +: FP_WIDTH]),
      .y_o   (c_div[s*FP_WIDTH +: FP_WIDTH])
    );

    assign z_exit[s*FP_WIDTH +: FP_WIDTH] =
      zw_pipe[DIV_LATENCY-1][s] ? '0 : z_div[s*FP_WIDTH +: FP_WIDTH];
    assign c_exit[s*FP_WIDTH +: FP_WIDTH] =
      wtz_pipe[DIV_LATENCY-1][s] ? '0 : c_div[s*FP_WIDTH +: FP_WIDTH];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      for (int i = 1; i < DIV_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Sideband data only matters under its valid bit, so it needs no reset.
  always_ff @(posedge clk_i) begin
    col_pipe[0] <= col_i;
    row_pipe[0] <= row_i;
    zw_pipe[0]  <= zw_in;
    wtz_pipe[0] <= wtz_in;
    for (int i = 1; i < DIV_LATENCY; i++) begin
      col_pipe[i] <= col_pipe[i-1];
      row_pipe[i] <= row_pipe[i-1];
      zw_pipe[i]  <= zw_pipe[i-1];
      wtz_pipe[i] <= wtz_pipe[i-1];
    end
  end

  assign exit_vld = vld_pipe[DIV_LATENCY-1];
  assign pop      = valid_o && ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      case ({accept, exit_vld})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      case ({exit_vld, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (exit_vld) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)      rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    end
  end

  // The credit rule guarantees a free slot whenever exit_vld is high.
  always_ff @(posedge clk_i) begin
    if (exit_vld) begin
      mem_z[wr_ptr]   <= z_exit;
      mem_c[wr_ptr]   <= c_exit;
      mem_zw[wr_ptr]  <= zw_pipe[DIV_LATENCY-1];
      mem_col[wr_ptr] <= col_pipe[DIV_LATENCY-1];
      mem_row[wr_ptr] <= row_pipe[DIV_LATENCY-1];
    end
  end

  assign valid_o  = (fifo_count != '0);
  assign z_o      = valid_o ? mem_z[rd_ptr]   : '0;
  assign c_o      = valid_o ? mem_c[rd_ptr]   : '0;
  assign zero_w_o = valid_o ? mem_zw[rd_ptr]  : '0;
  assign col_o    = valid_o ? mem_col[rd_ptr] : '0;
  assign row_o    = valid_o ? mem_row[rd_ptr] : '0;

endmodule
